// File: rtl/rf_ctrl_pkg.sv
// Shared widths, the write-back request record and the round-robin pick rule
// for the register-file write-back controller.
package rf_ctrl_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_PEND_W = 2;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] wa;
    logic [RF_DATA_W-1:0] wd;
  } wb_req_t;

  // One-hot grant; prio1 set means requester 1 wins a tie.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio1);
    logic [1:0] gnt;
    gnt[0] = req[0] & (~req[1] | ~prio1);
    gnt[1] = req[1] & (~req[0] | prio1);
    return gnt;
  endfunction
endpackage

// File: rtl/rf_wb_ctrl_if.sv
// Decode issue, hazard query, two write-back requesters and the reg_file write port.
interface rf_wb_ctrl_if
  import rf_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W
);
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_wa;
  logic                  issue_ready;
  logic [ADDR_WIDTH-1:0] ra0;
  logic [ADDR_WIDTH-1:0] ra1;
  logic                  hazard0;
  logic                  hazard1;
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_wa;
  logic [DATA_WIDTH-1:0] req0_wd;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_wa;
  logic [DATA_WIDTH-1:0] req1_wd;
  logic                  req1_ready;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_wa;
  logic [DATA_WIDTH-1:0] rf_wd;

  modport master (
    output issue_valid, issue_wa, ra0, ra1,
    output req0_valid, req0_wa, req0_wd, req1_valid, req1_wa, req1_wd,
    input  issue_ready, hazard0, hazard1, req0_ready, req1_ready,
    input  rf_we, rf_wa, rf_wd
  );

  modport slave (
    input  issue_valid, issue_wa, ra0, ra1,
    input  req0_valid, req0_wa, req0_wd, req1_valid, req1_wa, req1_wd,
    output issue_ready, hazard0, hazard1, req0_ready, req1_ready,
    output rf_we, rf_wa, rf_wd
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the side not granted last wins a tie.
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic prio1_q, prio1_d;

  assign gnt = rr_pick(req, prio1_q);

  // After serving requester 0 the next tie goes to requester 1, and vice versa.
  always_comb begin
    prio1_d = prio1_q;
    if (accept) prio1_d = gnt[0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) prio1_q <= 1'b0;
    else       prio1_q <= prio1_d;
  end
endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-back controller: arbitrates MEM/ALU write-backs onto the single reg_file
// write port and keeps a per-register pending-write scoreboard for RAW detection.
module rf_wb_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int PEND_W     = RF_PEND_W
)(
  input logic          clk,
  input logic          rstn,
  rf_wb_ctrl_if.slave  bus
);
  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [1:0] gnt;
  logic       accept;
  wb_req_t    sel;
  wb_req_t    wb_q, wb_d;
  logic       rf_we_q, rf_we_d;
  logic [PEND_W-1:0] cnt_q [NREG];
  logic [PEND_W-1:0] cnt_d [NREG];
  logic       issue_take;

  rr_arb2 u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .req    ({bus.req1_valid, bus.req0_valid}),
    .accept (accept),
    .gnt    (gnt)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign accept         = |gnt;

  always_comb begin
    sel.wa = bus.req0_wa;
    sel.wd = bus.req0_wd;
    if (gnt[1]) begin
      sel.wa = bus.req1_wa;
      sel.wd = bus.req1_wd;
    end
  end

  // Writes to x0 are accepted but never reach reg_file.
  always_comb begin
    rf_we_d = accept && (sel.wa != '0);
    wb_d    = accept ? sel : wb_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_we_q <= 1'b0;
      wb_q    <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      wb_q    <= wb_d;
    end
  end

  assign bus.rf_we = rf_we_q;
  assign bus.rf_wa = wb_q.wa;
  assign bus.rf_wd = wb_q.wd;

  assign issue_take      = bus.issue_valid && bus.issue_ready && (bus.issue_wa != '0);
  assign bus.issue_ready = (bus.issue_wa == '0) || (cnt_q[bus.issue_wa] != CNT_MAX);
  assign bus.hazard0     = (bus.ra0 != '0) && (cnt_q[bus.ra0] != '0);
  assign bus.hazard1     = (bus.ra1 != '0) && (cnt_q[bus.ra1] != '0);

  // Entry 0 is skipped so x0 never looks pending.
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 1; r < NREG; r++) begin
      logic inc, dec;
      inc = issue_take && (bus.issue_wa == ADDR_WIDTH'(r));
      dec = rf_we_q && (wb_q.wa == ADDR_WIDTH'(r));
      if (inc && !dec)
        cnt_d[r] = cnt_q[r] + 1'b1;
      else if (dec && !inc && (cnt_q[r] != '0))
        cnt_d[r] = cnt_q[r] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
    rf_we_q |-> (cnt_q[wb_q.wa] != '0));
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Bench for rf_wb_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_rf_wb_ctrl;
  import rf_ctrl_pkg::*;

  localparam int PMAX = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  rf_wb_ctrl_if bus ();

  rf_wb_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: pending counts, last granted side, and the write port contents.
  int          m_cnt [32];
  int          owed  [32];
  bit          m_last;
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  bit          last_acc0, last_acc1;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_last = 1'b1;
    m_we   = 1'b0;
    m_wa   = '0;
    m_wd   = '0;
    last_acc0 = 1'b0;
    last_acc1 = 1'b0;
  endfunction

  function automatic bit exp_rdy0();
    return bus.req0_valid && (!bus.req1_valid || m_last);
  endfunction

  function automatic bit exp_rdy1();
    return bus.req1_valid && (!bus.req0_valid || !m_last);
  endfunction

  function automatic bit exp_issue_ready(input logic [4:0] wa);
    return (wa == 0) || (m_cnt[wa] < PMAX);
  endfunction

  function automatic bit exp_hazard(input logic [4:0] ra);
    return (ra != 0) && (m_cnt[ra] > 0);
  endfunction

  task automatic tick();
    bit a0, a1, iss;
    @(posedge clk);
    a0  = exp_rdy0();
    a1  = exp_rdy1();
    iss = bus.issue_valid && (bus.issue_wa != 0) && (m_cnt[bus.issue_wa] < PMAX);
    if (m_we && m_cnt[m_wa] > 0) m_cnt[m_wa]--;
    if (iss) begin
      m_cnt[bus.issue_wa]++;
      owed[bus.issue_wa]++;
    end
    last_acc0 = a0;
    last_acc1 = a1;
    if (a0 || a1) begin
      m_last = a1;
      m_wa   = a1 ? bus.req1_wa : bus.req0_wa;
      m_wd   = a1 ? bus.req1_wd : bus.req0_wd;
      m_we   = (m_wa != 0);
    end else begin
      m_we = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.req0_valid  = 1'b0;
    bus.req1_valid  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.rf_we !== 1'b0 || bus.rf_wa !== 5'd0 || bus.rf_wd !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs got we=%0b wa=%0d wd=%0h exp 0/0/0", bus.rf_we, bus.rf_wa, bus.rf_wd);
    end
    checks++;
    if (bus.req0_valid !== 1'b0 || bus.issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_issue_ready got=%0b exp=1", bus.issue_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    tick();
    checks++;
    if (bus.rf_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_we got=%0b exp=0", bus.rf_we);
    end
  endtask

  task automatic test_single_write();
    idle();
    bus.issue_valid = 1'b1; bus.issue_wa = 5'd5; bus.ra0 = 5'd5;
    #1;
    checks++;
    if (bus.issue_ready !== 1'b1) begin
      failures++; $display("FAIL single_issue_ready got=%0b exp=1", bus.issue_ready);
    end
    tick();
    bus.issue_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_wa = 5'd5; bus.req1_wd = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.hazard0 !== 1'b1 || bus.req1_ready !== 1'b1) begin
      failures++; $display("FAIL single_hazard_ready got haz=%0b rdy=%0b exp 1/1", bus.hazard0, bus.req1_ready);
    end
    tick();
    bus.req1_valid = 1'b0;
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_wa !== 5'd5 || bus.rf_wd !== 32'hDEADBEEF || bus.hazard0 !== 1'b1) begin
      failures++;
      $display("FAIL single_write got we=%0b wa=%0d wd=%0h haz=%0b exp 1/5/deadbeef/1",
               bus.rf_we, bus.rf_wa, bus.rf_wd, bus.hazard0);
    end
    tick();
    checks++;
    if (bus.rf_we !== 1'b0 || bus.hazard0 !== 1'b0 || bus.rf_wa !== 5'd5) begin
      failures++;
      $display("FAIL single_after got we=%0b haz=%0b wa=%0d exp 0/0/5", bus.rf_we, bus.hazard0, bus.rf_wa);
    end
  endtask

  task automatic test_contention();
    logic [4:0] wseq [4] = '{5'd3, 5'd3, 5'd4, 5'd4};
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.issue_valid = 1'b1; bus.issue_wa = wseq[i];
      tick();
    end
    bus.issue_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_wa = 5'd3; bus.req0_wd = 32'hAAAA0003;
    bus.req1_valid = 1'b1; bus.req1_wa = 5'd4; bus.req1_wd = 32'hBBBB0004;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1)) begin
        failures++;
        $display("FAIL contention_grant%0d got r0=%0b r1=%0b exp r0=%0b", i, bus.req0_ready, bus.req1_ready, i % 2 == 0);
      end
      tick();
      checks++;
      if (bus.rf_we !== 1'b1 || bus.rf_wa !== ((i % 2 == 0) ? 5'd3 : 5'd4) ||
          bus.rf_wd !== ((i % 2 == 0) ? 32'hAAAA0003 : 32'hBBBB0004)) begin
        failures++;
        $display("FAIL contention_write%0d got we=%0b wa=%0d wd=%0h", i, bus.rf_we, bus.rf_wa, bus.rf_wd);
      end
    end
    idle();
    bus.ra0 = 5'd3; bus.ra1 = 5'd4;
    tick();
    checks++;
    if (bus.hazard0 !== 1'b0 || bus.hazard1 !== 1'b0 || bus.rf_we !== 1'b0) begin
      failures++;
      $display("FAIL contention_drain got h0=%0b h1=%0b we=%0b exp 0/0/0", bus.hazard0, bus.hazard1, bus.rf_we);
    end
  endtask

  task automatic test_x0();
    idle();
    bus.issue_valid = 1'b1; bus.issue_wa = 5'd0; bus.ra0 = 5'd0;
    #1;
    checks++;
    if (bus.issue_ready !== 1'b1) begin
      failures++; $display("FAIL x0_issue_ready got=%0b exp=1", bus.issue_ready);
    end
    tick();
    bus.issue_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_wa = 5'd0; bus.req0_wd = 32'h1234;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.hazard0 !== 1'b0) begin
      failures++; $display("FAIL x0_ready got rdy=%0b haz=%0b exp 1/0", bus.req0_ready, bus.hazard0);
    end
    tick();
    bus.req0_valid = 1'b0;
    checks++;
    if (bus.rf_we !== 1'b0 || bus.hazard0 !== 1'b0) begin
      failures++; $display("FAIL x0_no_write got we=%0b haz=%0b exp 0/0", bus.rf_we, bus.hazard0);
    end
  endtask

  task automatic test_saturation();
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.issue_valid = 1'b1; bus.issue_wa = 5'd7;
      tick();
    end
    #1;
    checks++;
    if (bus.issue_ready !== 1'b0) begin
      failures++; $display("FAIL sat_full got issue_ready=%0b exp=0", bus.issue_ready);
    end
    tick();
    bus.issue_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_wa = 5'd7; bus.req0_wd = 32'h0000_7777;
    tick();
    bus.req0_valid = 1'b0;
    checks++;
    if (bus.rf_we !== 1'b1 || bus.issue_ready !== 1'b0) begin
      failures++; $display("FAIL sat_same_cycle got we=%0b issue_ready=%0b exp 1/0", bus.rf_we, bus.issue_ready);
    end
    tick();
    checks++;
    if (bus.issue_ready !== 1'b1) begin
      failures++; $display("FAIL sat_release got issue_ready=%0b exp=1", bus.issue_ready);
    end
    bus.req0_valid = 1'b1;
    tick();
    tick();
    bus.req0_valid = 1'b0;
    bus.ra0 = 5'd7;
    tick();
    checks++;
    if (bus.hazard0 !== 1'b0) begin
      failures++; $display("FAIL sat_drain got hazard0=%0b exp=0", bus.hazard0);
    end
  endtask

  task automatic test_simultaneous();
    idle();
    bus.issue_valid = 1'b1; bus.issue_wa = 5'd9; bus.ra1 = 5'd9;
    tick();
    bus.issue_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_wa = 5'd9; bus.req1_wd = 32'h9999_0001;
    tick();
    bus.req1_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_wa = 5'd9;
    #1;
    checks++;
    if (bus.rf_we !== 1'b1 || bus.issue_ready !== 1'b1) begin
      failures++; $display("FAIL simul_setup got we=%0b issue_ready=%0b exp 1/1", bus.rf_we, bus.issue_ready);
    end
    tick();
    bus.issue_valid = 1'b0;
    #1;
    checks++;
    if (bus.hazard1 !== 1'b1 || bus.rf_we !== 1'b0) begin
      failures++; $display("FAIL simul_hold got hazard1=%0b we=%0b exp 1/0", bus.hazard1, bus.rf_we);
    end
    bus.req0_valid = 1'b1; bus.req0_wa = 5'd9; bus.req0_wd = 32'h9999_0002;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    checks++;
    if (bus.hazard1 !== 1'b0) begin
      failures++; $display("FAIL simul_single_pending got hazard1=%0b exp=0", bus.hazard1);
    end
  endtask

  task automatic pick_req(input bit hold, output bit v, output logic [4:0] wa);
    logic [4:0] r;
    v  = hold;
    wa = 5'd0;
    if (hold) return;
    if ($urandom_range(0, 9) < 7) begin
      r = 5'($urandom_range(0, 7));
      if (r == 0) begin
        v = 1'b1;
      end else if (owed[r] > 0) begin
        owed[r]--;
        v  = 1'b1;
        wa = r;
      end
    end
    if (v) wa = r;
  endtask

  task automatic test_random();
    bit v; logic [4:0] wa;
    idle();
    for (int i = 0; i < 32; i++) owed[i] = 0;
    last_acc0 = 1'b0; last_acc1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(bus.req0_valid && !last_acc0)) begin
        pick_req(1'b0, v, wa);
        bus.req0_valid = v;
        if (v) begin bus.req0_wa = wa; bus.req0_wd = $urandom; end
      end
      if (!(bus.req1_valid && !last_acc1)) begin
        pick_req(1'b0, v, wa);
        bus.req1_valid = v;
        if (v) begin bus.req1_wa = wa; bus.req1_wd = $urandom; end
      end
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_wa    = 5'($urandom_range(0, 7));
      bus.ra0         = 5'($urandom_range(0, 7));
      bus.ra1         = 5'($urandom_range(0, 7));
      #1;
      checks++;
      if (bus.issue_ready !== exp_issue_ready(bus.issue_wa) ||
          bus.hazard0 !== exp_hazard(bus.ra0) || bus.hazard1 !== exp_hazard(bus.ra1)) begin
        failures++;
        $display("FAIL rand_comb c=%0d got ir=%0b h0=%0b h1=%0b exp ir=%0b h0=%0b h1=%0b", c,
                 bus.issue_ready, bus.hazard0, bus.hazard1,
                 exp_issue_ready(bus.issue_wa), exp_hazard(bus.ra0), exp_hazard(bus.ra1));
      end
      checks++;
      if (bus.req0_ready !== exp_rdy0() || bus.req1_ready !== exp_rdy1()) begin
        failures++;
        $display("FAIL rand_grant c=%0d got r0=%0b r1=%0b exp r0=%0b r1=%0b", c,
                 bus.req0_ready, bus.req1_ready, exp_rdy0(), exp_rdy1());
      end
      tick();
      checks++;
      if (bus.rf_we !== m_we || (m_we && (bus.rf_wa !== m_wa || bus.rf_wd !== m_wd))) begin
        failures++;
        $display("FAIL rand_write c=%0d got we=%0b wa=%0d wd=%0h exp we=%0b wa=%0d wd=%0h", c,
                 bus.rf_we, bus.rf_wa, bus.rf_wd, m_we, m_wa, m_wd);
      end
    end
    idle();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    bit any_haz;
    idle();
    bus.issue_valid = 1'b1; bus.issue_wa = 5'd20;
    tick();
    bus.issue_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_wa = 5'd20; bus.req0_wd = 32'hCAFE_F00D;
    tick();
    bus.req0_valid = 1'b0;
    checks++;
    if (bus.rf_we !== 1'b1) begin
      failures++; $display("FAIL midreset_pre got we=%0b exp=1", bus.rf_we);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.rf_we !== 1'b0 || bus.rf_wa !== 5'd0 || bus.rf_wd !== 32'd0) begin
      failures++;
      $display("FAIL midreset_outputs got we=%0b wa=%0d wd=%0h exp 0/0/0", bus.rf_we, bus.rf_wa, bus.rf_wd);
    end
    any_haz = 1'b0;
    for (int r = 0; r < 32; r++) begin
      bus.ra0 = 5'(r); bus.ra1 = 5'(31 - r);
      #0.1;
      if (bus.hazard0 !== 1'b0 || bus.hazard1 !== 1'b0) any_haz = 1'b1;
    end
    checks++;
    if (any_haz) begin
      failures++; $display("FAIL midreset_hazards got any=1 exp=0");
    end
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    bus.ra0 = 5'd20;
    tick();
    checks++;
    if (bus.rf_we !== 1'b0 || bus.hazard0 !== 1'b0) begin
      failures++; $display("FAIL midreset_after got we=%0b haz=%0b exp 0/0", bus.rf_we, bus.hazard0);
    end
  endtask

  initial begin
    bus.issue_valid = 1'b0; bus.issue_wa = '0;
    bus.ra0 = '0; bus.ra1 = '0;
    bus.req0_valid = 1'b0; bus.req0_wa = '0; bus.req0_wd = '0;
    bus.req1_valid = 1'b0; bus.req1_wa = '0; bus.req1_wd = '0;
    model_reset();
    for (int i = 0; i < 32; i++) owed[i] = 0;
    #1;
    rstn = 1'b0;
    test_reset();
    test_single_write();
    test_contention();
    test_x0();
    test_saturation();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
